// File: rtl/xbar_slave_arbiter.sv
// xbar_slave_arbiter
// Lets two crossbar masters share one req/ack slave port. Requests are
// arbitrated round-robin. The winning master's address, command and write data
// are latched, and the slave is driven from that latched copy. The slave's
// answer is returned to the winner as a one-cycle ack. A watchdog finishes an
// access the slave never acknowledges and flags it as an error.

module xbar_slave_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_cmd,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_cmd,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_cmd,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,

  output logic [1:0]        grant
);

  // The timer only has to reach TIMEOUT-1. A disabled watchdog still keeps a
  // 1-bit timer, which saturates instead of wrapping.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic              last_grant;
  logic              owner;
  logic [TW-1:0]     timer;
  logic              win;
  logic              timed_out;
  logic              finish;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Pick the winner: a lone requester wins; on a tie the master that was not served last wins
  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) begin
      win = ~last_grant;
    end else if (m1_req) begin
      win = 1'b1;
    end
  end

  // The access ends on a slave ack or on watchdog expiry. An ack in the same cycle beats the timeout.
  always_comb begin
    timed_out = WDOG_EN && (timer == TIMER_LAST);
    finish    = (state == BUSY) && (s_ack || timed_out);
    rsp_data  = (s_ack && !s_cmd) ? s_rdata : '0;
    rsp_err   = ~s_ack;
  end

  assign grant = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

  // Arbitration FSM and slave-side registers. The latched request stays fixed until the access ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      timer      <= '0;
      s_req      <= 1'b0;
      s_addr     <= '0;
      s_cmd      <= 1'b0;
      s_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner   <= win;
            s_addr  <= win ? m1_addr  : m0_addr;
            s_cmd   <= win ? m1_cmd   : m0_cmd;
            s_wdata <= win ? m1_wdata : m0_wdata;
            timer   <= '0;
            s_req   <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (timer != TIMER_MAX) begin
            timer <= timer + TW'(1);
          end
          if (finish) begin
            s_req <= 1'b0;
            state <= RESP;
          end
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: begin
          s_req <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Send the result to the owning master as a single-cycle ack; rdata/err are zero whenever ack is low
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_ack   <= 1'b0;
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
    end else begin
      m0_ack   <= 1'b0;
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
      if (finish) begin
        if (owner) begin
          m1_ack   <= 1'b1;
          m1_rdata <= rsp_data;
          m1_err   <= rsp_err;
        end else begin
          m0_ack   <= 1'b1;
          m0_rdata <= rsp_data;
          m0_err   <= rsp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// tb_xbar_slave_arbiter
// Directed bench for xbar_slave_arbiter with the watchdog set to 8 cycles.
// A transaction-level model predicts every output on every cycle. Directed
// scenarios also pin down literal values: latencies, grant order, write data
// seen by the slave and error flags.

module tb_xbar_slave_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              m0_req = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic              m0_cmd = 1'b0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;
  logic              m1_req = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic              m1_cmd = 1'b0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;
  logic              s_req;
  logic [ADDR_W-1:0] s_addr;
  logic              s_cmd;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ack = 1'b0;
  logic [DATA_W-1:0] s_rdata = '0;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  xbar_slave_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m0_req  (m0_req),
    .m0_addr (m0_addr),
    .m0_cmd  (m0_cmd),
    .m0_wdata(m0_wdata),
    .m0_ack  (m0_ack),
    .m0_rdata(m0_rdata),
    .m0_err  (m0_err),
    .m1_req  (m1_req),
    .m1_addr (m1_addr),
    .m1_cmd  (m1_cmd),
    .m1_wdata(m1_wdata),
    .m1_ack  (m1_ack),
    .m1_rdata(m1_rdata),
    .m1_err  (m1_err),
    .s_req   (s_req),
    .s_addr  (s_addr),
    .s_cmd   (s_cmd),
    .s_wdata (s_wdata),
    .s_ack   (s_ack),
    .s_rdata (s_rdata),
    .grant   (grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Count one comparison and report a mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model. owner is -1 while nobody holds the slave.
  // "waited" counts how many slave cycles the current access has consumed.
  int                mdl_owner = -1;
  int                mdl_waited = 0;
  bit                mdl_answered = 1'b0;
  int                mdl_last = 1;
  bit                model_valid = 1'b0;
  logic [ADDR_W-1:0] mdl_addr = '0;
  logic              mdl_cmd = 1'b0;
  logic [DATA_W-1:0] mdl_wdata = '0;
  logic [DATA_W-1:0] mdl_rdata = '0;
  bit                mdl_err = 1'b0;

  // Advance the model by one clock, using the inputs the DUT samples on this edge
  always @(posedge clk) begin
    if (reset) begin
      mdl_owner    = -1;
      mdl_answered = 1'b0;
      mdl_last     = 1;
      mdl_addr     = '0;
      mdl_cmd      = 1'b0;
      mdl_wdata    = '0;
      mdl_rdata    = '0;
      mdl_err      = 1'b0;
      model_valid  = 1'b1;
    end else if (mdl_owner < 0) begin
      if (m0_req || m1_req) begin
        if (m0_req && m1_req) mdl_owner = 1 - mdl_last;
        else                  mdl_owner = m0_req ? 0 : 1;
        mdl_addr     = (mdl_owner == 0) ? m0_addr  : m1_addr;
        mdl_cmd      = (mdl_owner == 0) ? m0_cmd   : m1_cmd;
        mdl_wdata    = (mdl_owner == 0) ? m0_wdata : m1_wdata;
        mdl_waited   = 0;
        mdl_answered = 1'b0;
      end
    end else if (!mdl_answered) begin
      mdl_waited++;
      if (s_ack) begin
        mdl_answered = 1'b1;
        mdl_rdata    = mdl_cmd ? '0 : s_rdata;
        mdl_err      = 1'b0;
      end else if (TIMEOUT > 0 && mdl_waited == TIMEOUT) begin
        mdl_answered = 1'b1;
        mdl_rdata    = '0;
        mdl_err      = 1'b1;
      end
    end else begin
      mdl_last     = mdl_owner;
      mdl_owner    = -1;
      mdl_answered = 1'b0;
    end
  end

  bit e_ack0, e_ack1;

  // Compare every DUT output with the model, midway between active edges
  always @(negedge clk) begin
    if (model_valid) begin
      e_ack0 = mdl_answered && (mdl_owner == 0);
      e_ack1 = mdl_answered && (mdl_owner == 1);
      checkOutput("s_req",    s_req,    (mdl_owner >= 0) && !mdl_answered);
      checkOutput("grant",    grant,    (mdl_owner < 0) ? 2'b00 : ((mdl_owner == 0) ? 2'b01 : 2'b10));
      checkOutput("s_addr",   s_addr,   mdl_addr);
      checkOutput("s_cmd",    s_cmd,    mdl_cmd);
      checkOutput("s_wdata",  s_wdata,  mdl_wdata);
      checkOutput("m0_ack",   m0_ack,   e_ack0);
      checkOutput("m0_rdata", m0_rdata, e_ack0 ? mdl_rdata : '0);
      checkOutput("m0_err",   m0_err,   e_ack0 ? mdl_err : 1'b0);
      checkOutput("m1_ack",   m1_ack,   e_ack1);
      checkOutput("m1_rdata", m1_rdata, e_ack1 ? mdl_rdata : '0);
      checkOutput("m1_err",   m1_err,   e_ack1 ? mdl_err : 1'b0);
    end
  end

  // Scripted masters, slave and observation logs
  logic [ADDR_W-1:0] q_addr  [2][8];
  logic              q_cmd   [2][8];
  logic [DATA_W-1:0] q_wdata [2][8];
  int                q_len   [2] = '{0, 0};
  int                q_head  [2] = '{0, 0};
  int                q_start [2] = '{0, 0};
  int                cyc = 0;
  int                slave_k = 1;
  logic [DATA_W-1:0] slave_data = '0;
  int                bcount = 0;
  int                stray_ack_at = -1;
  int                grant_log[$];
  logic [DATA_W-1:0] wr_log[$];
  logic [1:0]        prev_grant = 2'b00;
  int                ack_cnt    [2] = '{0, 0};
  logic [DATA_W-1:0] last_rdata [2];
  logic              last_err   [2];
  int                ack_cycle  [2] = '{0, 0};
  int                req_cycle  [2] = '{0, 0};
  int                sreq_cycles = 0;

  task automatic driveMaster(input int i);
    bit act;
    act = (q_head[i] < q_len[i]) && (cyc >= q_start[i]);
    if (i == 0) begin
      if (act && !m0_req) req_cycle[0] = cyc;
      m0_req = act;
      if (act) begin
        m0_addr  = q_addr[0][q_head[0]];
        m0_cmd   = q_cmd[0][q_head[0]];
        m0_wdata = q_wdata[0][q_head[0]];
      end
    end else begin
      if (act && !m1_req) req_cycle[1] = cyc;
      m1_req = act;
      if (act) begin
        m1_addr  = q_addr[1][q_head[1]];
        m1_cmd   = q_cmd[1][q_head[1]];
        m1_wdata = q_wdata[1][q_head[1]];
      end
    end
  endtask

  // Observe the current cycle, then drive the slave and both masters for the next edge
  task automatic applyStimulus();
    cyc++;
    if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back((grant == 2'b01) ? 0 : 1);
    prev_grant = grant;
    if (s_req) sreq_cycles++;
    if (m0_ack) begin
      ack_cnt[0]++; last_rdata[0] = m0_rdata; last_err[0] = m0_err; ack_cycle[0] = cyc; q_head[0]++;
    end
    if (m1_ack) begin
      ack_cnt[1]++; last_rdata[1] = m1_rdata; last_err[1] = m1_err; ack_cycle[1] = cyc; q_head[1]++;
    end
    if (s_req) begin
      bcount++;
      s_ack = (slave_k > 0) && (bcount == slave_k);
    end else begin
      bcount = 0;
      s_ack  = (cyc == stray_ack_at);
    end
    s_rdata = slave_data;
    if (s_ack && s_req && s_cmd) wr_log.push_back(s_wdata);
    driveMaster(0);
    driveMaster(1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic loadTxn(input int i, input logic [ADDR_W-1:0] a, input logic c, input logic [DATA_W-1:0] d);
    q_addr[i][q_len[i]]  = a;
    q_cmd[i][q_len[i]]   = c;
    q_wdata[i][q_len[i]] = d;
    q_len[i]++;
  endtask

  task automatic clearLogs();
    grant_log.delete();
    wr_log.delete();
    ack_cnt     = '{0, 0};
    sreq_cycles = 0;
  endtask

  task automatic resetDut();
    reset  = 1'b1;
    q_len  = '{0, 0};
    q_head = '{0, 0};
    step();
    step();
    reset = 1'b0;
    clearLogs();
  endtask

  task automatic runUntilIdle(input int budget);
    int n;
    n = 0;
    while (!(q_head[0] >= q_len[0] && q_head[1] >= q_len[1] && s_req == 1'b0 && grant == 2'b00)) begin
      if (n >= budget) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL idle_wait: still busy after %0d cycles, required idle", budget);
        return;
      end
      step();
      n++;
    end
    step();
  endtask

  int cnt;

  initial begin
    #1;
    resetDut();
    checkOutput("reset_grant",  grant,  2'b00);
    checkOutput("reset_s_req",  s_req,  1'b0);
    checkOutput("reset_m0_ack", m0_ack, 1'b0);
    checkOutput("reset_s_addr", s_addr, 32'h0);

    // m0 read at 0x10; the slave acks in the 2nd busy cycle with 0x1234; a stray idle s_ack must be ignored
    slave_k = 2; slave_data = 32'h1234; stray_ack_at = cyc + 1;
    q_start[0] = cyc + 3;
    loadTxn(0, 32'h10, 1'b0, 32'h0);
    runUntilIdle(40);
    stray_ack_at = -1;
    checkOutput("t1_m0_acks",   ack_cnt[0],    1);
    checkOutput("t1_m0_rdata",  last_rdata[0], 32'h1234);
    checkOutput("t1_m0_err",    last_err[0],   1'b0);
    checkOutput("t1_m1_acks",   ack_cnt[1],    0);
    checkOutput("t1_latency",   ack_cycle[0] - req_cycle[0], 3);

    // both masters write continuously, four transactions each
    resetDut();
    slave_k = 1; q_start = '{cyc + 1, cyc + 1};
    for (int j = 0; j < 4; j++) begin
      loadTxn(0, 32'h1000 + 32'(j * 4), 1'b1, 32'h100 + 32'(j));
      loadTxn(1, 32'h2000 + 32'(j * 4), 1'b1, 32'h200 + 32'(j));
    end
    runUntilIdle(200);
    checkOutput("t2_grants", grant_log.size(), 8);
    for (int j = 0; j < grant_log.size(); j++) checkOutput("t2_grant_order", grant_log[j], j % 2);
    checkOutput("t2_writes", wr_log.size(), 8);
    for (int j = 0; j < 4; j++) begin
      for (int m = 0; m < 2; m++) begin
        cnt = 0;
        foreach (wr_log[w]) if (wr_log[w] == ((m == 0) ? 32'h100 : 32'h200) + 32'(j)) cnt++;
        checkOutput("t2_wdata_once", cnt, 1);
      end
    end

    // m1 write 0xA5A5 at 0x20; m0 raises req while m1 is being served
    resetDut();
    slave_k = 4; q_start = '{cyc + 3, cyc + 1};
    loadTxn(1, 32'h20, 1'b1, 32'hA5A5);
    loadTxn(0, 32'h30, 1'b0, 32'h0);
    runUntilIdle(60);
    checkOutput("t3_grants",  grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      checkOutput("t3_first",  grant_log[0], 1);
      checkOutput("t3_second", grant_log[1], 0);
    end
    checkOutput("t3_writes", wr_log.size(), 1);
    if (wr_log.size() == 1) checkOutput("t3_wdata", wr_log[0], 32'hA5A5);

    // slave never acks: the watchdog ends the access after 8 cycles
    clearLogs();
    slave_k = 0; slave_data = 32'hDEAD; q_start[0] = cyc + 1;
    loadTxn(0, 32'h44, 1'b0, 32'h0);
    runUntilIdle(60);
    checkOutput("t4_sreq_cycles", sreq_cycles,   8);
    checkOutput("t4_m0_err",      last_err[0],   1'b1);
    checkOutput("t4_m0_rdata",    last_rdata[0], 32'h0);
    checkOutput("t4_latency",     ack_cycle[0] - req_cycle[0], 9);

    // ack in the same cycle the watchdog would fire: the ack wins
    clearLogs();
    slave_k = 8; slave_data = 32'hCAFE; q_start[0] = cyc + 1;
    loadTxn(0, 32'h48, 1'b0, 32'h0);
    runUntilIdle(60);
    checkOutput("t5_m0_err",      last_err[0],   1'b0);
    checkOutput("t5_m0_rdata",    last_rdata[0], 32'hCAFE);
    checkOutput("t5_sreq_cycles", sreq_cycles,   8);

    // reset while m1 is busy: the access is dropped and m0 wins the next tie
    resetDut();
    slave_k = 0; q_start = '{0, cyc + 1};
    loadTxn(1, 32'h40, 1'b1, 32'h77);
    cnt = 0;
    while (!s_req && cnt < 10) begin step(); cnt++; end
    checkOutput("t6_busy_reached", s_req, 1'b1);
    step();
    q_start[0] = cyc;
    loadTxn(0, 32'h50, 1'b0, 32'h0);
    reset = 1'b1;
    step();
    checkOutput("t6_rst_s_req",  s_req,      1'b0);
    checkOutput("t6_rst_grant",  grant,      2'b00);
    checkOutput("t6_rst_m1_ack", ack_cnt[1], 0);
    reset = 1'b0;
    grant_log.delete(); wr_log.delete();
    slave_k = 1;
    runUntilIdle(60);
    checkOutput("t6_grants", grant_log.size(), 2);
    if (grant_log.size() >= 1) checkOutput("t6_first_m0", grant_log[0], 0);
    checkOutput("t6_m1_acks", ack_cnt[1], 1);
    checkOutput("t6_writes",  wr_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] global timeout");
  end

endmodule
